util_tx_timestamp_gate: RTL and testbench

Single-clock scheduler in the DAC clock domain, placed between the timestamp-interleaved DMA sample stream and the DAC-side unpacker. It parses a header word carrying a 64-bit launch time, then holds back the following block of sample words until the free-running DAC timestamp reaches that launch time. Blocks whose header is late or too far in the future are discarded and reported. The block sequences the datapath only; it does not pack, unpack or cross clocks.

---
 rtl/util_tx_timestamp_gate.sv | 171 +++++++++++++++++
 tb/tb_util_tx_timestamp_gate.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/util_tx_timestamp_gate.sv
// Launch-time scheduler for a timestamp-interleaved DAC sample stream.
// Holds each block until the DAC timestamp reaches its header time; late or too-early blocks are dropped.
module util_tx_timestamp_gate #(
    parameter int DATA_WIDTH      = 64,
    parameter int BLOCK_LEN_WIDTH = 16,
    parameter int COUNT_WIDTH     = 16
) (
    input  logic                       dac_clk,
    input  logic                       reset,
    input  logic [BLOCK_LEN_WIDTH-1:0] block_len,
    input  logic [31:0]                early_limit,
    input  logic [63:0]                timestamp,
    input  logic                       s_axis_valid,
    output logic                       s_axis_ready,
    input  logic [DATA_WIDTH-1:0]      s_axis_data,
    input  logic                       s_axis_xfer_req,
    output logic                       m_axis_valid,
    input  logic                       m_axis_ready,
    output logic [DATA_WIDTH-1:0]      m_axis_data,
    output logic                       flush,
    output logic                       late_pulse,
    output logic                       early_pulse,
    output logic                       underrun,
    output logic [COUNT_WIDTH-1:0]     late_count,
    output logic [COUNT_WIDTH-1:0]     early_count,
    output logic [2:0]                 state
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PASS   = 3'd1,
        ST_HDR    = 3'd2,
        ST_WAIT   = 3'd3,
        ST_STREAM = 3'd4,
        ST_DROP   = 3'd5
    } state_e;

    state_e                     state_q, state_d;
    logic [BLOCK_LEN_WIDTH-1:0] blk_len_q, blk_len_d;
    logic [BLOCK_LEN_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
    logic [63:0]                ts_cap_q, ts_cap_d;
    logic [COUNT_WIDTH-1:0]     late_cnt_q, late_cnt_d;
    logic [COUNT_WIDTH-1:0]     early_cnt_q, early_cnt_d;
    logic                       late_q, late_d;
    logic                       early_q, early_d;
    logic                       flush_q, flush_d;

    logic signed [63:0] hdr_diff;
    logic signed [63:0] wait_diff;
    logic               fwd;
    logic               in_beat;
    logic               out_beat;

    // Wrap-safe signed distances to launch time, so headers across the bit-63 boundary still order correctly.
    assign hdr_diff  = $signed(s_axis_data[63:0] - timestamp);
    assign wait_diff = $signed(ts_cap_q - timestamp);

    assign fwd          = (state_q == ST_PASS) || (state_q == ST_STREAM);
    assign m_axis_valid = fwd & s_axis_valid;
    assign m_axis_data  = fwd ? s_axis_data : '0;
    assign in_beat      = s_axis_valid & s_axis_ready;
    assign out_beat     = m_axis_valid & m_axis_ready;
    assign underrun     = (state_q == ST_STREAM) & m_axis_ready & ~s_axis_valid;

    assign flush       = flush_q;
    assign late_pulse  = late_q;
    assign early_pulse = early_q;
    assign late_count  = late_cnt_q;
    assign early_count = early_cnt_q;
    assign state       = state_q;

    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_d      = state_q;
        blk_len_d    = blk_len_q;
        beat_cnt_d   = beat_cnt_q;
        ts_cap_d     = ts_cap_q;
        late_cnt_d   = late_cnt_q;
        early_cnt_d  = early_cnt_q;
        late_d       = 1'b0;
        early_d      = 1'b0;
        flush_d      = 1'b0;
        s_axis_ready = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (s_axis_xfer_req) begin
                    blk_len_d = block_len;
                    state_d   = (block_len == '0) ? ST_PASS : ST_HDR;
                end
            end
            ST_PASS: s_axis_ready = m_axis_ready;
            ST_HDR: begin
                s_axis_ready = 1'b1;
                if (in_beat) begin
                    ts_cap_d   = s_axis_data[63:0];
                    beat_cnt_d = blk_len_q;
                    if (hdr_diff <= 64'sd0) begin
                        state_d    = ST_DROP;
                        late_d     = 1'b1;
                        flush_d    = 1'b1;
                        late_cnt_d = (&late_cnt_q) ? late_cnt_q : late_cnt_q + COUNT_WIDTH'(1);
                    end else if (hdr_diff > $signed({32'd0, early_limit})) begin
                        state_d     = ST_DROP;
                        early_d     = 1'b1;
                        flush_d     = 1'b1;
                        early_cnt_d = (&early_cnt_q) ? early_cnt_q : early_cnt_q + COUNT_WIDTH'(1);
                    end else if (hdr_diff == 64'sd1) begin
                        state_d = ST_STREAM;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (wait_diff <= 64'sd1) state_d = ST_STREAM;
            end
            ST_STREAM: begin
                s_axis_ready = m_axis_ready;
                if (out_beat) begin
                    beat_cnt_d = beat_cnt_q - BLOCK_LEN_WIDTH'(1);
                    if (beat_cnt_q == BLOCK_LEN_WIDTH'(1)) state_d = ST_HDR;
                end
            end
            ST_DROP: begin
                s_axis_ready = 1'b1;
                if (in_beat) begin
                    beat_cnt_d = beat_cnt_q - BLOCK_LEN_WIDTH'(1);
                    if (beat_cnt_q == BLOCK_LEN_WIDTH'(1)) state_d = ST_HDR;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // An abort discards any header verdict from this cycle.
        if ((state_q != ST_IDLE) && !s_axis_xfer_req) begin
            state_d     = ST_IDLE;
            late_d      = 1'b0;
            early_d     = 1'b0;
            flush_d     = 1'b0;
            late_cnt_d  = late_cnt_q;
            early_cnt_d = early_cnt_q;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge dac_clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            blk_len_q   <= '0;
            beat_cnt_q  <= '0;
            ts_cap_q    <= '0;
            late_cnt_q  <= '0;
            early_cnt_q <= '0;
            late_q      <= 1'b0;
            early_q     <= 1'b0;
            flush_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            blk_len_q   <= blk_len_d;
            beat_cnt_q  <= beat_cnt_d;
            ts_cap_q    <= ts_cap_d;
            late_cnt_q  <= late_cnt_d;
            early_cnt_q <= early_cnt_d;
            late_q      <= late_d;
            early_q     <= early_d;
            flush_q     <= flush_d;
        end
    end

endmodule

// File: tb/tb_util_tx_timestamp_gate.sv
// Bench for util_tx_timestamp_gate: header-classification vector table plus hand sequences,
// with forwarded words checked against a scoreboard of expected data and launch times.
module tb_util_tx_timestamp_gate;

    localparam int DW     = 64;
    localparam int BLW    = 16;
    localparam int CW     = 3;
    localparam int BUDGET = 400;

    logic           dac_clk = 1'b0;
    logic           reset = 1'b1;
    logic [BLW-1:0] block_len = '0;
    logic [31:0]    early_limit = '0;
    logic [63:0]    timestamp = 64'd1000;
    logic           s_axis_valid = 1'b0;
    logic           s_axis_ready;
    logic [DW-1:0]  s_axis_data = '0;
    logic           s_axis_xfer_req = 1'b0;
    logic           m_axis_valid;
    logic           m_axis_ready = 1'b1;
    logic [DW-1:0]  m_axis_data;
    logic           flush, late_pulse, early_pulse, underrun;
    logic [CW-1:0]  late_count, early_count;
    logic [2:0]     state;

    always #5 dac_clk = ~dac_clk;

    util_tx_timestamp_gate #(
        .DATA_WIDTH(DW), .BLOCK_LEN_WIDTH(BLW), .COUNT_WIDTH(CW)
    ) dut (
        .dac_clk(dac_clk), .reset(reset), .block_len(block_len), .early_limit(early_limit),
        .timestamp(timestamp), .s_axis_valid(s_axis_valid), .s_axis_ready(s_axis_ready),
        .s_axis_data(s_axis_data), .s_axis_xfer_req(s_axis_xfer_req),
        .m_axis_valid(m_axis_valid), .m_axis_ready(m_axis_ready), .m_axis_data(m_axis_data),
        .flush(flush), .late_pulse(late_pulse), .early_pulse(early_pulse), .underrun(underrun),
        .late_count(late_count), .early_count(early_count), .state(state)
    );

    typedef struct {
        logic [63:0] data;
        logic [63:0] ts;
        bit          ts_chk;
    } sb_item_t;

    typedef enum int {C_STREAM, C_WAIT, C_LATE, C_EARLY} cls_e;

    typedef struct {
        logic [63:0] delta;
        logic [31:0] lim;
        cls_e        cls;
    } vec_t;

    sb_item_t sb_q[$];
    vec_t     vecs[10];

    int n_checks = 0;
    int n_pass = 0;
    int late_seen = 0;
    int early_seen = 0;
    int flush_seen = 0;
    int underrun_seen = 0;
    int late_exp = 0;
    int early_exp = 0;
    bit in_beat = 1'b0;
    bit rand_ready = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // One clock: observe outputs at the falling edge, then advance time after the rising edge.
    task automatic tick();
        sb_item_t it;
        @(negedge dac_clk);
        in_beat = s_axis_valid && s_axis_ready;
        if (late_pulse)  late_seen++;
        if (early_pulse) early_seen++;
        if (flush)       flush_seen++;
        if (underrun)    underrun_seen++;
        if (m_axis_valid && m_axis_ready) begin
            if (sb_q.size() == 0) begin
                check("sb_nonempty_on_output", 64'(sb_q.size()), 64'd1);
            end else begin
                it = sb_q.pop_front();
                check("out_data", m_axis_data, it.data);
                if (it.ts_chk) check("out_time", timestamp, it.ts);
            end
        end
        @(posedge dac_clk);
        #1;
        timestamp = timestamp + 64'd1;
        if (rand_ready) m_axis_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send_word(input logic [63:0] d, output int stalls);
        int n;
        n = 0;
        s_axis_valid = 1'b1;
        s_axis_data  = d;
        do begin
            tick();
            n++;
        end while (!in_beat && n < BUDGET);
        if (!in_beat) check("handshake_timeout", 64'(in_beat), 64'd1);
        stalls = n - 1;
    endtask

    task automatic run_vector(input vec_t v, input int idx);
        logic [63:0] hdr;
        int          st, l0, e0, f0, exp_stall;
        bit          fwd;
        early_limit = v.lim;
        hdr = timestamp + v.delta;
        l0 = late_seen; e0 = early_seen; f0 = flush_seen;
        fwd = (v.cls == C_STREAM) || (v.cls == C_WAIT);
        exp_stall = (v.cls == C_WAIT) ? int'(v.delta) - 1 : 0;
        for (int i = 0; i < 4; i++)
            if (fwd) sb_q.push_back('{data: 64'hA000_0000_0000_0000 | 64'(idx << 8) | 64'(i),
                                      ts: hdr + 64'(i), ts_chk: 1'b1});
        send_word(hdr, st);
        check("hdr_accept_stall", 64'(st), 64'd0);
        send_word(64'hA000_0000_0000_0000 | 64'(idx << 8), st);
        check("first_sample_stall", 64'(st), 64'(exp_stall));
        for (int i = 1; i < 4; i++) send_word(64'hA000_0000_0000_0000 | 64'(idx << 8) | 64'(i), st);
        if (v.cls == C_LATE)  late_exp  = (late_exp  == 7) ? 7 : late_exp + 1;
        if (v.cls == C_EARLY) early_exp = (early_exp == 7) ? 7 : early_exp + 1;
        check("state_after_block", 64'(state), 64'd2);
        check("late_pulse_cycles", 64'(late_seen - l0), 64'(v.cls == C_LATE));
        check("early_pulse_cycles", 64'(early_seen - e0), 64'(v.cls == C_EARLY));
        check("flush_cycles", 64'(flush_seen - f0), 64'(!fwd));
        check("late_count", 64'(late_count), 64'(late_exp));
        check("early_count", 64'(early_count), 64'(early_exp));
    endtask

    initial begin
        int   st, u0, f0;
        vec_t lv;

        vecs[0] = '{delta: 64'd1,                     lim: 32'd1000,       cls: C_STREAM};
        vecs[1] = '{delta: 64'd5,                     lim: 32'd1000,       cls: C_WAIT};
        vecs[2] = '{delta: -64'sd10,                  lim: 32'd1000,       cls: C_LATE};
        vecs[3] = '{delta: 64'd2,                     lim: 32'd1000,       cls: C_WAIT};
        vecs[4] = '{delta: 64'd0,                     lim: 32'd1000,       cls: C_LATE};
        vecs[5] = '{delta: 64'd200,                   lim: 32'd128,        cls: C_EARLY};
        vecs[6] = '{delta: 64'd128,                   lim: 32'd128,        cls: C_WAIT};
        vecs[7] = '{delta: 64'd129,                   lim: 32'd128,        cls: C_EARLY};
        vecs[8] = '{delta: 64'h8000_0000_0000_0005,   lim: 32'hFFFF_FFFF,  cls: C_LATE};
        vecs[9] = '{delta: 64'h7FFF_FFFF_FFFF_FFFF,   lim: 32'hFFFF_FFFF,  cls: C_EARLY};

        repeat (3) tick();
        check("rst_state", 64'(state), 64'd0);
        check("rst_s_ready", 64'(s_axis_ready), 64'd0);
        check("rst_m_valid", 64'(m_axis_valid), 64'd0);
        check("rst_late_count", 64'(late_count), 64'd0);
        check("rst_early_count", 64'(early_count), 64'd0);
        reset = 1'b0;
        tick();

        // Pass-through with random downstream backpressure.
        block_len = '0;
        s_axis_xfer_req = 1'b1;
        tick();
        check("pass_state", 64'(state), 64'd1);
        rand_ready = 1'b1;
        for (int i = 1; i <= 48; i++) sb_q.push_back('{data: 64'(i), ts: 64'd0, ts_chk: 1'b0});
        for (int i = 1; i <= 48; i++) send_word(64'(i), st);
        rand_ready = 1'b0;
        m_axis_ready = 1'b1;
        s_axis_valid = 1'b0;
        check("pass_state_end", 64'(state), 64'd1);
        check("pass_no_flush", 64'(flush_seen + late_seen + early_seen), 64'd0);
        check("pass_all_out", 64'(sb_q.size()), 64'd0);

        s_axis_xfer_req = 1'b0;
        tick();
        check("idle_after_pass", 64'(state), 64'd0);
        block_len = 16'd4;
        s_axis_xfer_req = 1'b1;
        tick();
        check("hdr_state", 64'(state), 64'd2);
        block_len = 16'd7;

        timestamp = 64'd100;
        for (int v = 0; v < 10; v++) run_vector(vecs[v], v);
        check("vectors_all_out", 64'(sb_q.size()), 64'd0);

        lv = '{delta: -64'sd3, lim: 32'd1000, cls: C_LATE};
        for (int k = 0; k < 6; k++) run_vector(lv, 16 + k);

        // Upstream stall inside a stream block.
        early_limit = 32'd1000;
        for (int i = 0; i < 4; i++) sb_q.push_back('{data: 64'hB0 + 64'(i), ts: 64'd0, ts_chk: 1'b0});
        send_word(timestamp + 64'd1, st);
        send_word(64'hB0, st);
        send_word(64'hB1, st);
        s_axis_valid = 1'b0;
        u0 = underrun_seen;
        tick();
        tick();
        check("underrun_cycles", 64'(underrun_seen - u0), 64'd2);
        check("stall_state", 64'(state), 64'd4);
        send_word(64'hB2, st);
        send_word(64'hB3, st);
        check("stall_block_end", 64'(state), 64'd2);
        check("stall_all_out", 64'(sb_q.size()), 64'd0);

        // Abort while waiting for launch time.
        f0 = flush_seen;
        send_word(timestamp + 64'd20, st);
        s_axis_data = 64'hC0;
        repeat (3) tick();
        check("wait_state", 64'(state), 64'd3);
        check("wait_s_ready", 64'(s_axis_ready), 64'd0);
        check("wait_m_valid", 64'(m_axis_valid), 64'd0);
        check("wait_m_data", m_axis_data, 64'd0);
        s_axis_xfer_req = 1'b0;
        tick();
        check("abort_state", 64'(state), 64'd0);
        check("abort_no_flush", 64'(flush_seen - f0), 64'd0);
        s_axis_valid = 1'b0;

        // Reset in the middle of a stream block.
        block_len = 16'd4;
        s_axis_xfer_req = 1'b1;
        tick();
        st = 0;
        sb_q.push_back('{data: 64'hD0, ts: timestamp + 64'd1, ts_chk: 1'b1});
        sb_q.push_back('{data: 64'hD1, ts: timestamp + 64'd2, ts_chk: 1'b1});
        send_word(timestamp + 64'd1, st);
        send_word(64'hD0, st);
        send_word(64'hD1, st);
        check("pre_rst_state", 64'(state), 64'd4);
        check("pre_rst_late_count", 64'(late_count), 64'(late_exp));
        s_axis_valid = 1'b0;
        reset = 1'b1;
        tick();
        check("mid_rst_state", 64'(state), 64'd0);
        check("mid_rst_s_ready", 64'(s_axis_ready), 64'd0);
        check("mid_rst_m_valid", 64'(m_axis_valid), 64'd0);
        check("mid_rst_underrun", 64'(underrun), 64'd0);
        check("mid_rst_pulses", 64'({flush, late_pulse, early_pulse}), 64'd0);
        check("mid_rst_late_count", 64'(late_count), 64'd0);
        check("mid_rst_early_count", 64'(early_count), 64'd0);
        check("mid_rst_sb_empty", 64'(sb_q.size()), 64'd0);
        reset = 1'b0;
        s_axis_xfer_req = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
